// File: rtl/vga_pkg.sv
// Shared VGA timing constants and fetch types, common to the timing generator and vga_fetch.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package vga_pkg;

  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_TOTAL    = 800;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_TOTAL    = 525;
  localparam int BYTES_PER_LINE = 80;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetchState_t;

  // line * 80 built as line*64 + line*16. Only used to re-seed the line-base
  // accumulator when its history is unknown (after a mid-frame reset).
  function automatic logic [15:0] lineOffset(input logic [8:0] line);
    return {1'b0, line, 6'b0} + {3'b0, line, 4'b0};
  endfunction

endpackage

// File: rtl/vga_fetch_if.sv
// Framebuffer read bus: request held until a one-clk acknowledge that carries the data.
// Latency: set by the memory; mem_data is valid in the mem_ack clk.
// Backpressure: the memory stalls by withholding mem_ack while mem_rd stays high.
// Ports: mem_addr/mem_rd driven by the fetcher (master), mem_ack/mem_data by the memory (slave).
interface vga_fetch_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [7:0]  mem_data;

  modport master (output mem_addr, mem_rd, input mem_ack, mem_data);
  modport slave  (input mem_addr, mem_rd, output mem_ack, mem_data);
endinterface

// File: rtl/vga_shifter.sv
// 8-bit MSB-first pixel shift register with parallel load and shift enables.
// Latency: nextMsb shows, combinationally, the MSB the register holds after this clk.
// Backpressure: none; load wins over shift, both low holds.
// Ports: clk, rst_n, load, shift, din[7:0] in; nextMsb out.
module vga_shifter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] din,
  output logic       nextMsb
);

  logic [7:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 8'h00;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[6:0], 1'b0};
    end
  end

  // The pixel for the current column is the MSB after this clk's load/shift,
  // so the caller can register it with exactly one pixel period of delay.
  assign nextMsb = load ? din[7] : (shift ? q[6] : q[7]);

endmodule

// File: rtl/vga_fetch.sv
// 1 bpp framebuffer fetch: prefetches one byte group ahead and serialises it to vout with aligned syncs.
// Latency: vout/hsync/vsync are registered one pixel period after x_pos/y_pos.
// Backpressure: a fetch not acknowledged by its load point blanks that group and sets sticky underrun.
// Ports: clk, rst_n; pix_en, x_pos, y_pos, hsync_in, vsync_in timing in; mem (master) framebuffer bus;
//        vout, hsync, vsync video out; underrun sticky error.
module vga_fetch
  import vga_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          H_ACTIVE  = DEF_H_ACTIVE,
  parameter int          H_TOTAL   = DEF_H_TOTAL,
  parameter int          V_ACTIVE  = DEF_V_ACTIVE,
  parameter int          V_TOTAL   = DEF_V_TOTAL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic [9:0]  x_pos,
  input  logic [8:0]  y_pos,
  input  logic        hsync_in,
  input  logic        vsync_in,
  vga_fetch_if.master mem,
  output logic        vout,
  output logic        hsync,
  output logic        vsync,
  output logic        underrun
);

  localparam logic [9:0] H_ACT        = 10'(H_ACTIVE);
  localparam logic [9:0] LAST_FETCH_X = 10'(H_ACTIVE - 8);
  localparam logic [9:0] NEXT_LINE_X  = 10'(H_TOTAL - 8);
  localparam logic [8:0] V_ACT        = 9'(V_ACTIVE);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);

  fetchState_t state;
  logic [7:0]  holdReg;
  logic        holdValid;
  logic [15:0] lineBase;   // address of group 0 of the current line
  logic        baseValid;  // lineBase has followed the frame since reset
  logic        primed;     // a group-0 prefetch has been issued since reset

  logic        active, groupStart, loadPt, shiftEn, lineEnd;
  logic        groupReq, lineReq, reqFire, starved, ackTaken, shMsb;
  logic [8:0]  nextY;
  logic [6:0]  nextGroup;
  logic [15:0] nextBase, reqAddr;

  assign active     = (x_pos < H_ACT) && (y_pos < V_ACT);
  assign groupStart = pix_en && (x_pos[2:0] == 3'd0);
  assign loadPt     = groupStart && active;
  assign shiftEn    = pix_en && active && (x_pos[2:0] != 3'd0);
  assign lineEnd    = pix_en && (x_pos == NEXT_LINE_X);

  // Compared 10 bits wide so a V_TOTAL beyond the port range cannot alias a
  // real line; the 9-bit increment rolls over to 0 on its own after 511.
  assign nextY = ({1'b0, y_pos} == V_LAST) ? 9'd0 : y_pos + 9'd1;

  assign nextBase = (nextY == 9'd0) ? BASE_ADDR :
                    baseValid       ? lineBase + 16'(BYTES_PER_LINE) :
                                      BASE_ADDR + lineOffset(nextY);

  assign nextGroup = x_pos[9:3] + 7'd1;

  // Mid-line prefetches wait for primed: until then lineBase may belong to
  // another line, and the pixels they feed are blanked anyway.
  assign groupReq = primed && groupStart && (x_pos < LAST_FETCH_X) && (y_pos < V_ACT);
  assign lineReq  = lineEnd && (nextY < V_ACT);
  assign reqFire  = groupReq || lineReq;
  assign reqAddr  = lineReq ? nextBase : lineBase + {9'd0, nextGroup};

  // Before the first group-0 prefetch the blank loads are expected, not errors.
  assign starved  = loadPt && primed && !holdValid;
  // An ack racing a missed deadline or a new request belongs to a dead fetch.
  assign ackTaken = (state == REQ) && mem.mem_ack && !reqFire && !starved;

  // Request FSM and holding register: run every clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mem.mem_rd   <= 1'b0;
      mem.mem_addr <= 16'h0000;
      holdReg      <= 8'h00;
      holdValid    <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      if (starved || (reqFire && (state == REQ))) begin
        underrun <= 1'b1;
      end

      if (reqFire) begin
        state        <= REQ;
        mem.mem_rd   <= 1'b1;
        mem.mem_addr <= reqAddr;
      end else if (starved) begin
        state      <= IDLE;
        mem.mem_rd <= 1'b0;
      end else if (ackTaken) begin
        state      <= IDLE;
        mem.mem_rd <= 1'b0;
        holdReg    <= mem.mem_data;
      end

      if (loadPt) begin
        holdValid <= 1'b0;
      end else if (ackTaken) begin
        holdValid <= 1'b1;
      end
    end
  end

  // Pixel-rate state: advances only on pix_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vout      <= 1'b0;
      hsync     <= 1'b0;
      vsync     <= 1'b0;
      lineBase  <= BASE_ADDR;
      baseValid <= 1'b0;
      primed    <= 1'b0;
    end else if (pix_en) begin
      vout  <= shMsb && active;
      hsync <= hsync_in;
      vsync <= vsync_in;
      if (lineEnd) begin
        lineBase  <= nextBase;
        baseValid <= 1'b1;
        if (lineReq) begin
          primed <= 1'b1;
        end
      end
    end
  end

  vga_shifter u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (loadPt),
    .shift   (shiftEn),
    .din     (holdValid ? holdReg : 8'h00),
    .nextMsb (shMsb)
  );

endmodule

// File: tb/tb_vga_fetch.sv
// Directed bench for vga_fetch: the bench acts as timing generator and as two framebuffer
// memories (byte = address low byte). The 9-bit line port cannot carry 525 lines, so both
// instances run a 500-line frame; the frame-start line is therefore 499.
module tb_vga_fetch;
  import vga_pkg::*;

  localparam int VT = 500;
  localparam int K_VOUT = 0, K_HS = 1, K_VS = 2, K_REQ = 3, K_RD = 4, K_VOUT2 = 5, K_REQ2 = 6;

  typedef struct {
    int y;
    int x;
    int kind;
    int exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_en = 1'b0;
  logic [9:0] x_pos = '0;
  logic [8:0] y_pos = '0;
  logic       hsync_in = 1'b0;
  logic       vsync_in = 1'b0;
  logic       vout, hsync, vsync, underrun;
  logic       vout2, hsync2, vsync2, underrun2;

  vga_fetch_if mem1 ();
  vga_fetch_if mem2 ();

  vga_fetch #(.V_TOTAL(VT)) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x_pos(x_pos), .y_pos(y_pos),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .mem(mem1),
    .vout(vout), .hsync(hsync), .vsync(vsync), .underrun(underrun)
  );

  vga_fetch #(.BASE_ADDR(16'hFFF0), .V_TOTAL(VT)) dut2 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x_pos(x_pos), .y_pos(y_pos),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .mem(mem2),
    .vout(vout2), .hsync(hsync2), .vsync(vsync2), .underrun(underrun2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  // memory model state
  int          slowAddr = -1;
  int          slowDelay = 20;
  logic [15:0] cur1 = '0, cur2 = '0;
  int          wait1 = 0, wait2 = 0;

  // captures per pixel of the line just run
  logic        capV [800];
  logic        capH [800];
  logic        capVs[800];
  logic        rd1  [800];
  logic [15:0] ad1  [800];
  logic        capV2[800];
  logic        rd2  [800];
  logic [15:0] ad2  [800];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic addVec(input int y, input int x, input int k, input int e);
    vec_t v;
    v.y = y; v.x = x; v.kind = k; v.exp = e;
    vecs.push_back(v);
  endtask

  // Memories acknowledge after mem_rd has been seen for `delay` rising edges
  // with a stable address; a changed or dropped request restarts the count.
  task automatic memModel();
    int d;
    if (mem1.mem_rd) begin
      if (wait1 > 0 && mem1.mem_addr == cur1) wait1++;
      else begin cur1 = mem1.mem_addr; wait1 = 1; end
      d = (int'(cur1) == slowAddr) ? slowDelay : 1;
      mem1.mem_ack  = (wait1 >= d);
      mem1.mem_data = cur1[7:0];
    end else begin
      wait1 = 0; mem1.mem_ack = 1'b0; mem1.mem_data = 8'h00;
    end
    if (mem2.mem_rd) begin
      if (wait2 > 0 && mem2.mem_addr == cur2) wait2++;
      else begin cur2 = mem2.mem_addr; wait2 = 1; end
      mem2.mem_ack  = (wait2 >= 1);
      mem2.mem_data = cur2[7:0];
    end else begin
      wait2 = 0; mem2.mem_ack = 1'b0; mem2.mem_data = 8'h00;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    memModel();
  endtask

  task automatic clearCap();
    for (int i = 0; i < 800; i++) begin
      capV[i] = 1'b0; capH[i] = 1'b0; capVs[i] = 1'b0; rd1[i] = 1'b0; ad1[i] = '0;
      capV2[i] = 1'b0; rd2[i] = 1'b0; ad2[i] = '0;
    end
  endtask

  // One pixel period: pix_en for one clk, then an idle clk. Outputs are
  // sampled on the falling edge right after the pix_en clk.
  task automatic stepPix(input int x);
    x_pos    = 10'(x);
    hsync_in = (x >= 658 && x <= 753);
    vsync_in = (int'(y_pos) >= VT - 2);
    pix_en   = 1'b1;
    tick();
    pix_en   = 1'b0;
    capV[x] = vout;   capH[x] = hsync; capVs[x] = vsync;
    rd1[x]  = mem1.mem_rd; ad1[x] = mem1.mem_addr;
    capV2[x] = vout2; rd2[x] = mem2.mem_rd; ad2[x] = mem2.mem_addr;
    tick();
  endtask

  task automatic runSeg(input int x0, input int x1);
    for (int x = x0; x <= x1; x++) stepPix(x);
  endtask

  task automatic applyTable(input int y);
    foreach (vecs[i]) begin
      if (vecs[i].y == y) begin
        int    act;
        int    x;
        string kn;
        x = vecs[i].x;
        case (vecs[i].kind)
          K_VOUT:  begin act = int'(capV[x]);  kn = "vout";  end
          K_HS:    begin act = int'(capH[x]);  kn = "hsync"; end
          K_VS:    begin act = int'(capVs[x]); kn = "vsync"; end
          K_REQ:   begin act = rd1[x] ? int'(ad1[x]) : -1; kn = "req_addr"; end
          K_RD:    begin act = int'(rd1[x]);   kn = "mem_rd"; end
          K_VOUT2: begin act = int'(capV2[x]); kn = "wrap_vout"; end
          default: begin act = rd2[x] ? int'(ad2[x]) : -1; kn = "wrap_req_addr"; end
        endcase
        check($sformatf("y%0d_x%0d_%s", y, x, kn), act, vecs[i].exp);
      end
    end
  endtask

  task automatic runLine(input int y, input int x0);
    clearCap();
    y_pos = 9'(y);
    runSeg(x0, 799);
    applyTable(y);
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_vout"},     int'(vout),          0);
    check({tag, "_hsync"},    int'(hsync),         0);
    check({tag, "_vsync"},    int'(vsync),         0);
    check({tag, "_mem_rd"},   int'(mem1.mem_rd),   0);
    check({tag, "_mem_addr"}, int'(mem1.mem_addr), 0);
    check({tag, "_underrun"}, int'(underrun),      0);
    check({tag, "_wrap_addr"}, int'(mem2.mem_addr), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout actual running required finished");
    $fatal(1);
  end

  initial begin
    // frame-start line: group-0 prefetch of line 0 reloads BASE_ADDR
    addVec(499, 792, K_REQ, 0);
    addVec(499, 792, K_REQ2, 16'hFFF0);
    addVec(499, 700, K_VS, 1);
    // line 0: bytes equal address low byte
    addVec(0, 0, K_VS, 0);
    addVec(0, 0, K_VOUT, 0);
    addVec(0, 8, K_VOUT, 0);
    addVec(0, 14, K_VOUT, 0);
    addVec(0, 15, K_VOUT, 1);
    addVec(0, 8, K_REQ, 2);
    addVec(0, 22, K_VOUT, 1);
    addVec(0, 624, K_REQ, 79);
    addVec(0, 632, K_VOUT, 0);
    addVec(0, 633, K_VOUT, 1);
    addVec(0, 639, K_VOUT, 1);
    addVec(0, 640, K_VOUT, 0);
    addVec(0, 657, K_HS, 0);
    addVec(0, 658, K_HS, 1);
    addVec(0, 753, K_HS, 1);
    addVec(0, 754, K_HS, 0);
    addVec(0, 792, K_REQ, 80);
    addVec(0, 120, K_REQ2, 0);
    addVec(0, 120, K_VOUT2, 1);
    addVec(0, 128, K_VOUT2, 0);
    // line 1: base 80, group 1 = 8'h51
    addVec(1, 8, K_VOUT, 0);
    addVec(1, 9, K_VOUT, 1);
    addVec(1, 792, K_REQ, 160);
    // line 2: group 5 (addr 165) acknowledged too late
    addVec(2, 32, K_VOUT, 1);
    addVec(2, 39, K_RD, 1);
    addVec(2, 40, K_VOUT, 0);
    addVec(2, 42, K_VOUT, 0);
    addVec(2, 47, K_VOUT, 0);
    addVec(2, 40, K_REQ, 166);
    addVec(2, 48, K_VOUT, 1);
    addVec(2, 49, K_VOUT, 0);
    addVec(2, 53, K_VOUT, 1);
    addVec(2, 55, K_VOUT, 0);
    // line 3: last group (addr 319) late, request dropped with no successor
    addVec(3, 626, K_VOUT, 1);
    addVec(3, 631, K_RD, 1);
    addVec(3, 632, K_RD, 0);
    addVec(3, 634, K_VOUT, 0);
    addVec(3, 792, K_REQ, 320);
    // line 200 after mid-line reset: blank, no fetch until the group-0 prefetch
    addVec(200, 304, K_RD, 0);
    addVec(200, 304, K_VOUT, 0);
    addVec(200, 320, K_VOUT, 0);
    addVec(200, 792, K_REQ, 16080);
    // line 201: base 16080 = 16'h3ED0
    addVec(201, 0, K_VOUT, 1);
    addVec(201, 2, K_VOUT, 0);
    addVec(201, 3, K_VOUT, 1);
    addVec(201, 15, K_VOUT, 1);
    addVec(201, 8, K_REQ, 16082);
    // last active line
    addVec(478, 792, K_REQ, 38320);
    addVec(479, 624, K_REQ, 38399);
    addVec(479, 639, K_VOUT, 1);
    addVec(479, 640, K_VOUT, 0);
    addVec(479, 792, K_RD, 0);

    mem1.mem_ack = 1'b0; mem1.mem_data = 8'h00;
    mem2.mem_ack = 1'b0; mem2.mem_data = 8'h00;
    clearCap();
    tick();
    tick();
    checkReset("por");
    rst_n = 1'b1;
    tick();

    runLine(499, 600);
    runLine(0, 0);
    runLine(1, 0);
    check("underrun_clean", int'(underrun), 0);
    slowAddr = 165;
    runLine(2, 0);
    check("underrun_set", int'(underrun), 1);
    slowAddr = 319;
    runLine(3, 0);
    slowAddr = -1;
    check("underrun_sticky", int'(underrun), 1);

    // asynchronous reset in the middle of line 200
    clearCap();
    y_pos = 9'd200;
    runSeg(290, 299);
    check("pre_reset_addr_nonzero", int'(mem1.mem_addr != 16'h0000), 1);
    rst_n = 1'b0;
    #1;
    checkReset("midframe");
    repeat (5) tick();
    rst_n = 1'b1;
    runSeg(300, 799);
    applyTable(200);
    check("underrun_after_reset", int'(underrun), 0);
    runLine(201, 0);
    check("underrun_line201", int'(underrun), 0);

    // re-enter late in the frame to reach the last active line
    clearCap();
    y_pos = 9'd478;
    runSeg(690, 699);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    runSeg(700, 799);
    applyTable(478);
    runLine(479, 0);
    check("underrun_line479", int'(underrun), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
